// File: rtl/radix4_div_pkg.sv
// radix4_div_pkg: shared state encoding and width-derived special-case result patterns
//   state_t          - divider FSM states
//   dbz_quotient(w)  - all-ones quotient returned for a zero divisor, w bits wide
//   min_int(w)       - most negative two's-complement value, w bits wide
package radix4_div_pkg;

   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

   localparam int MAX_W = 64;
   localparam logic [MAX_W-1:0] ONES_MAX = '1;
   localparam logic [MAX_W-1:0] MSB_MAX = {1'b1, {(MAX_W-1){1'b0}}};

   function automatic logic [MAX_W-1:0] dbz_quotient(input int w);
      return ONES_MAX >> (MAX_W - w);
   endfunction

   function automatic logic [MAX_W-1:0] min_int(input int w);
      return MSB_MAX >> (MAX_W - w);
   endfunction

endpackage

// File: rtl/radix4_div_step.sv
// radix4_div_step: one combinational radix-4 restoring division step
//   p_i    - partial remainder (WIDTH+2 bits, always below the divisor)
//   d_i    - divisor magnitude, zero-extended to WIDTH+2 bits
//   bits_i - next two dividend bits, MSB first
//   p_o    - next partial remainder
//   k_o    - quotient digit 0..3
module radix4_div_step
   import radix4_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH+1:0] p_i,
   input  logic [WIDTH+1:0] d_i,
   input  logic [1:0]       bits_i,
   output logic [WIDTH+1:0] p_o,
   output logic [1:0]       k_o
);
   // Working at WIDTH+4 bits keeps every operand bit live; since p_i < d_i the
   // upper bits of t are always zero and the result fits back into WIDTH+2 bits.
   logic [WIDTH+3:0] t, d1, d2, d3, kd;

   always_comb begin
      t   = {p_i, bits_i};
      d1  = {2'b00, d_i};
      d2  = d1 << 1;
      d3  = d1 + d2;
      k_o = t >= d3 ? 2'd3 : t >= d2 ? 2'd2 : t >= d1 ? 2'd1 : 2'd0;
      kd  = k_o == 2'd3 ? d3 : k_o == 2'd2 ? d2 : k_o == 2'd1 ? d1 : '0;
      p_o = (WIDTH+2)'(t - kd);
   end

endmodule

// File: rtl/radix4_div.sv
// radix4_div: iterative radix-4 integer divider with RISC-V DIV/REM semantics
//   CLK, rst_n        - clock and synchronous active-low reset
//   vld_in / rdy_in   - operand handshake (A dividend, B divisor)
//   vld_out / rdy_out - result handshake (Q quotient, R remainder, dbz divide-by-zero)
module radix4_div
   import radix4_div_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b1
) (
   input  logic             CLK,
   input  logic             rst_n,
   input  logic             vld_in,
   output logic             rdy_in,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             dbz,
   output logic             vld_out,
   input  logic             rdy_out
);
   localparam int CW = $clog2(WIDTH/2);
   localparam logic [CW-1:0] LAST = CW'(WIDTH/2 - 1);
   localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(dbz_quotient(WIDTH));
   localparam logic [WIDTH-1:0] MIN_INT  = WIDTH'(min_int(WIDTH));

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, sr_q, q_q, r_q;
   logic [WIDTH+1:0] p_q, d_q, p_d;
   logic [CW-1:0]    cnt_q;
   logic [1:0]       k_d;
   logic             sa_q, sb_q, dbz_q, vld_q;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign a_neg   = SIGNED && a_q[WIDTH-1];
   assign b_neg   = SIGNED && b_q[WIDTH-1];
   assign a_mag   = a_neg ? -a_q : a_q;
   assign b_mag   = b_neg ? -b_q : b_q;
   assign rdy_in  = state_q == IDLE;
   assign Q       = q_q;
   assign R       = r_q;
   assign dbz     = dbz_q;
   assign vld_out = vld_q;

   // The dividend shift register doubles as the quotient register: each step
   // shifts two dividend bits out of the top and the new digit in at the bottom.
   radix4_div_step #(.WIDTH(WIDTH)) u_step (
      .p_i    (p_q),
      .d_i    (d_q),
      .bits_i (sr_q[WIDTH-1:WIDTH-2]),
      .p_o    (p_d),
      .k_o    (k_d)
   );

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state_q <= IDLE;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (vld_in) begin
               a_q     <= A;
               b_q     <= B;
               state_q <= PREP;
            end
            PREP: begin
               sa_q <= a_neg;
               sb_q <= b_neg;
               if (b_q == '0) begin
                  q_q     <= ALL_ONES;
                  r_q     <= a_q;
                  dbz_q   <= 1'b1;
                  vld_q   <= 1'b1;
                  state_q <= DONE;
               end else if (SIGNED && a_q == MIN_INT && b_q == ALL_ONES) begin
                  q_q     <= MIN_INT;
                  r_q     <= '0;
                  dbz_q   <= 1'b0;
                  vld_q   <= 1'b1;
                  state_q <= DONE;
               end else begin
                  p_q     <= '0;
                  d_q     <= {2'b00, b_mag};
                  sr_q    <= a_mag;
                  cnt_q   <= '0;
                  state_q <= ITER;
               end
            end
            ITER: begin
               p_q   <= p_d;
               sr_q  <= {sr_q[WIDTH-3:0], k_d};
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) state_q <= FIX;
            end
            FIX: begin
               q_q     <= (sa_q ^ sb_q) ? -sr_q : sr_q;
               r_q     <= sa_q ? -WIDTH'(p_q) : WIDTH'(p_q);
               dbz_q   <= 1'b0;
               vld_q   <= 1'b1;
               state_q <= DONE;
            end
            DONE: if (rdy_out) begin
               vld_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
